// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed 7-segment scanner for packed BCD digits
// Inputs are snapshotted at each frame wrap so a digit never tears mid-scan.
module bcd_display_scanner #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      lzb,
   input  logic                      blank,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic                      frame_done
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);

   logic [PW-1:0]             pre_q, pre_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]     sdp_q, sdp_d;
   logic [NUM_DIGITS-1:0]     an_d;
   logic [6:0]                seg_d;
   logic                      dp_d;
   logic                      fd_d;
   logic                      tc;
   logic                      wrap;
   logic [3:0]                cur;
   logic                      cur_dp;
   logic                      nonzero_above;
   logic                      blanked;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b1000000;
      endcase
   endfunction

   always_comb begin
      tc       = (pre_q == LAST_PRE);
      wrap     = tc && (idx_q == LAST_IDX);
      pre_d    = tc ? '0 : pre_q + PW'(1);
      idx_d    = idx_q;
      if (tc) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end
      shadow_d = wrap ? digits_in : shadow_q;
      sdp_d    = wrap ? dp_in : sdp_q;
      fd_d     = wrap;

      // Outputs follow next-state idx/shadow so they switch on the same edge as idx.
      cur           = '0;
      cur_dp        = 1'b0;
      nonzero_above = 1'b0;
      an_d          = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (int'(idx_d) == k) begin
            cur     = shadow_d[4*k +: 4];
            cur_dp  = sdp_d[k];
            an_d[k] = 1'b1;
         end
         if (k >= int'(idx_d) && shadow_d[4*k +: 4] != 4'd0) begin
            nonzero_above = 1'b1;
         end
      end
      blanked = lzb && (idx_d != '0) && !nonzero_above;

      seg_d = blanked ? 7'b0000000 : decode(cur);
      dp_d  = cur_dp;
      if (blank) begin
         an_d  = '0;
         seg_d = '0;
         dp_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         sdp_q      <= '0;
         an         <= '0;
         seg        <= '0;
         dp         <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         sdp_q      <= sdp_d;
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
         frame_done <= fd_d;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - self-checking bench for bcd_display_scanner (4 digits, SCAN_DIV=4)
module tb_bcd_display_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        lzb;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [3:0]  dpv;
      logic        lzb;
      logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[8];

   bcd_display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lzb        (lzb),
      .blank      (blank),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpv);
      exp_t e;
      logic [3:0] one;
      one = 4'b0001;
      for (int c = 0; c < 16; c++) begin
         e.an  = one << (c / 4);
         e.seg = segs[7*(c/4) +: 7];
         e.dp  = dpv[c/4];
         e.fd  = (c == 0);
         sb_q.push_back(e);
      end
   endtask

   task automatic check_frame(input string tag, input int chg_at, input logic [15:0] chg_val);
      exp_t e;
      for (int c = 0; c < 16; c++) begin
         if (sb_q.size() == 0) begin
            cmp({tag, "_sb_empty"}, 1, 0);
         end else begin
            e = sb_q.pop_front();
            cmp($sformatf("%s_an_c%0d", tag, c), 32'(an), 32'(e.an));
            cmp($sformatf("%s_seg_c%0d", tag, c), 32'(seg), 32'(e.seg));
            cmp($sformatf("%s_dp_c%0d", tag, c), 32'(dp), 32'(e.dp));
            cmp($sformatf("%s_fd_c%0d", tag, c), 32'(frame_done), 32'(e.fd));
         end
         if (c == chg_at) digits_in = chg_val;
         @(negedge clk);
      end
   endtask

   task automatic wait_frame(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (frame_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) cmp({tag, "_frame_timeout"}, 0, 1);
   endtask

   initial begin
      logic [3:0] one;
      one = 4'b0001;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
      vecs[1] = '{16'h0050, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b1101101, 7'b0111111}};
      vecs[2] = '{16'h0050, 4'b0000, 1'b0, {7'b0111111, 7'b0111111, 7'b1101101, 7'b0111111}};
      vecs[3] = '{16'h000A, 4'b0001, 1'b0, {7'b0111111, 7'b0111111, 7'b0111111, 7'b1000000}};
      vecs[4] = '{16'hB000, 4'b0000, 1'b1, {7'b1000000, 7'b0111111, 7'b0111111, 7'b0111111}};
      vecs[5] = '{16'h0000, 4'b1111, 1'b1, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
      vecs[6] = '{16'h9876, 4'b1010, 1'b0, {7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101}};
      vecs[7] = '{16'h0705, 4'b0100, 1'b1, {7'b0000000, 7'b0000111, 7'b0111111, 7'b1101101}};

      rst_n = 1'b0;
      digits_in = 16'h1234;
      dp_in = 4'b0000;
      lzb = 1'b0;
      blank = 1'b0;
      repeat (3) @(negedge clk);
      cmp("rst_an", 32'(an), 0);
      cmp("rst_seg", 32'(seg), 0);
      cmp("rst_dp", 32'(dp), 0);
      cmp("rst_fd", 32'(frame_done), 0);
      rst_n = 1'b1;

      // First frame shows the cleared shadow; snapshot lands on edge 16.
      for (int e = 1; e <= 16; e++) begin
         @(negedge clk);
         if (e < 16) begin
            cmp($sformatf("first_an_e%0d", e), 32'(an), 32'(one << (e / 4)));
            cmp($sformatf("first_seg_e%0d", e), 32'(seg), 32'(7'b0111111));
            cmp($sformatf("first_fd_e%0d", e), 32'(frame_done), 0);
         end else begin
            cmp("first_an_e16", 32'(an), 32'(4'b0001));
            cmp("first_seg_e16", 32'(seg), 32'(7'b1100110));
            cmp("first_fd_e16", 32'(frame_done), 1);
         end
      end

      // No tearing: inputs change at edge 20, display keeps 1234 until edge 32.
      push_frame(vecs[0].segs, 4'b0000);
      check_frame("tear_old", 4, 16'h9876);
      push_frame({7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101}, 4'b0000);
      check_frame("tear_new", -1, 16'h0);

      // Blank for 40 cycles starting at a frame boundary.
      blank = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         cmp($sformatf("blank_an_%0d", i), 32'(an), 0);
         cmp($sformatf("blank_seg_%0d", i), 32'(seg), 0);
         cmp($sformatf("blank_dp_%0d", i), 32'(dp), 0);
         cmp($sformatf("blank_fd_%0d", i), 32'(frame_done), 32'((i % 16) == 0));
      end
      blank = 1'b0;
      @(negedge clk);
      cmp("unblank_an", 32'(an), 32'(4'b0100));
      cmp("unblank_seg", 32'(seg), 32'(7'b1111111));

      for (int v = 0; v < 8; v++) begin
         digits_in = vecs[v].d;
         dp_in = vecs[v].dpv;
         lzb = vecs[v].lzb;
         wait_frame($sformatf("vec%0d", v));
         push_frame(vecs[v].segs, vecs[v].dpv);
         check_frame($sformatf("vec%0d", v), -1, 16'h0);
      end

      // Async reset between edges while frame_done and an are active.
      digits_in = 16'h5555;
      lzb = 1'b0;
      dp_in = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      cmp("arst_an", 32'(an), 0);
      cmp("arst_seg", 32'(seg), 0);
      cmp("arst_dp", 32'(dp), 0);
      cmp("arst_fd", 32'(frame_done), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(negedge clk);
         cmp($sformatf("arst_an_e%0d", e), 32'(an), 32'(one << (e / 4)));
         cmp($sformatf("arst_seg_e%0d", e), 32'(seg), 32'(7'b0111111));
         cmp($sformatf("arst_dp_e%0d", e), 32'(dp), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
